prga_decrypt: RTL and testbench

PRGA_DECRYPT -- requirements
Module: prga_decrypt

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/prga_decrypt.sv | 178 +++++++++++++++++
 tb/tb_prga_decrypt.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decryption stages: PRGA state encoding,
// message geometry and the printable-character bounds used by the range check.
package rc4_pkg;

    localparam int         MSG_LEN    = 32;
    localparam logic [4:0] MSG_LAST   = 5'd31;
    localparam logic [7:0] CHAR_LO    = 8'h61;
    localparam logic [7:0] CHAR_HI    = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INC_I   = 4'd1,
        ST_WAIT_I  = 4'd2,
        ST_LATCH_I = 4'd3,
        ST_WAIT_J  = 4'd4,
        ST_LATCH_J = 4'd5,
        ST_WR_I    = 4'd6,
        ST_WR_J    = 4'd7,
        ST_WAIT_F  = 4'd8,
        ST_LATCH_F = 4'd9,
        ST_WR_OUT  = 4'd10,
        ST_NEXT    = 4'd11,
        ST_DONE    = 4'd12,
        ST_FAIL    = 4'd13
    } prga_state_t;

    function automatic logic char_valid(input logic [7:0] b);
        return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
    endfunction

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA stage: generates 32 keystream bytes from the S RAM and XORs them with
// the encrypted ROM. Optional plaintext range check enabled by RANGE_CHECK_EN.
module prga_decrypt
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start_flag,
    output logic       done_flag,
    output logic       fail_flag,
    output logic [7:0] s_address,
    output logic [7:0] s_data_in,
    input  logic [7:0] s_data_out,
    output logic       s_wren,
    output logic [4:0] rom_address,
    input  logic [7:0] rom_q,
    output logic [4:0] out_address,
    output logic [7:0] out_data,
    output logic       out_wren
);

    prga_state_t state_r;
    prga_state_t next_state_s;
    logic        wait_phase_r;
    logic [7:0]  i_r;
    logic [7:0]  j_r;
    logic [7:0]  si_r;
    logic [7:0]  sj_r;
    logic [4:0]  k_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; WAIT_F spends one cycle issuing the f/ROM reads and one waiting
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_flag) begin
                    next_state_s = ST_INC_I;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INC_I:   next_state_s = ST_WAIT_I;
            ST_WAIT_I:  next_state_s = ST_LATCH_I;
            ST_LATCH_I: next_state_s = ST_WAIT_J;
            ST_WAIT_J:  next_state_s = ST_LATCH_J;
            ST_LATCH_J: next_state_s = ST_WR_I;
            ST_WR_I:    next_state_s = ST_WR_J;
            ST_WR_J:    next_state_s = ST_WAIT_F;
            ST_WAIT_F: begin
                if (wait_phase_r) begin
                    next_state_s = ST_LATCH_F;
                end else begin
                    next_state_s = ST_WAIT_F;
                end
            end
            ST_LATCH_F: next_state_s = ST_WR_OUT;
            ST_WR_OUT: begin
`ifdef RANGE_CHECK_EN
                if (!char_valid(out_data)) begin
                    next_state_s = ST_FAIL;
                end else begin
                    next_state_s = ST_NEXT;
                end
`else
                next_state_s = ST_NEXT;
`endif
            end
            ST_NEXT: begin
                if (k_r == MSG_LAST) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_INC_I;
                end
            end
            ST_DONE:    next_state_s = ST_DONE;
            ST_FAIL:    next_state_s = ST_FAIL;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Datapath and registered memory ports; each state's outputs are loaded on the edge entering it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_phase_r <= 1'b0;
            i_r          <= 8'd0;
            j_r          <= 8'd0;
            si_r         <= 8'd0;
            sj_r         <= 8'd0;
            k_r          <= 5'd0;
            s_address    <= 8'd0;
            s_data_in    <= 8'd0;
            s_wren       <= 1'b0;
            rom_address  <= 5'd0;
            out_address  <= 5'd0;
            out_data     <= 8'd0;
            out_wren     <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            done_flag <= (next_state_s == ST_DONE) || (next_state_s == ST_FAIL);
            case (state_r)
                ST_INC_I: begin
                    i_r       <= i_r + 8'd1;
                    s_address <= i_r + 8'd1;
                end
                ST_LATCH_I: begin
                    si_r      <= s_data_out;
                    j_r       <= j_r + s_data_out;
                    s_address <= j_r + s_data_out;
                end
                ST_LATCH_J: begin
                    sj_r      <= s_data_out;
                    s_address <= i_r;
                    s_data_in <= s_data_out;
                    s_wren    <= 1'b1;
                end
                ST_WR_I: begin
                    s_address <= j_r;
                    s_data_in <= si_r;
                    s_wren    <= 1'b1;
                end
                ST_WR_J: begin
                    s_wren <= 1'b0;
                end
                ST_WAIT_F: begin
                    if (!wait_phase_r) begin
                        s_address    <= si_r + sj_r;
                        rom_address  <= k_r;
                        wait_phase_r <= 1'b1;
                    end else begin
                        wait_phase_r <= 1'b0;
                    end
                end
                ST_LATCH_F: begin
                    out_address <= k_r;
                    out_data    <= s_data_out ^ rom_q;
                    out_wren    <= 1'b1;
                end
                ST_WR_OUT: begin
                    out_wren <= 1'b0;
                end
                ST_NEXT: begin
                    if (k_r != MSG_LAST) begin
                        k_r <= k_r + 5'd1;
                    end else begin
                        k_r <= k_r;
                    end
                end
                default: begin
                    s_wren   <= 1'b0;
                    out_wren <= 1'b0;
                end
            endcase
        end
    end

`ifdef RANGE_CHECK_EN
    // Sticky failure indication, set on entry to FAIL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_flag <= 1'b0;
        end else begin
            fail_flag <= (next_state_s == ST_FAIL);
        end
    end
`else
    assign fail_flag = 1'b0;
`endif

endmodule

// File: tb/tb_prga_decrypt.sv
// Self-checking bench for prga_decrypt: table of message setups, software RC4
// model feeding a write scoreboard, plus reset-abort and DONE-idle sequences.
module tb_prga_decrypt;
    import rc4_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_flag = 1'b0;
    logic       done_flag, fail_flag, s_wren, out_wren;
    logic [7:0] s_address, s_data_in, s_data_out, rom_q, out_data;
    logic [4:0] rom_address, out_address;

    always #5 clk = ~clk;

    prga_decrypt dut (
        .clk(clk), .reset(reset), .start_flag(start_flag),
        .done_flag(done_flag), .fail_flag(fail_flag),
        .s_address(s_address), .s_data_in(s_data_in), .s_data_out(s_data_out), .s_wren(s_wren),
        .rom_address(rom_address), .rom_q(rom_q),
        .out_address(out_address), .out_data(out_data), .out_wren(out_wren)
    );

`ifdef RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    // Memory models: synchronous address register, read data from the registered address
    logic [7:0] s_mem [256];
    logic [7:0] s_init [256];
    logic [7:0] enc_init [32];
    logic [7:0] out_mem [32];
    logic [7:0] s_aq = 8'h00;
    logic [4:0] rom_aq = 5'd0;
    logic       load_mem = 1'b0;
    int         cyc = 0;

    assign s_data_out = s_mem[s_aq];
    assign rom_q      = enc_init[rom_aq];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        s_aq   <= s_address;
        rom_aq <= rom_address;
        if (load_mem) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_wren) begin
            s_mem[s_address] <= s_data_in;
        end
    end

    always @(posedge clk) begin
        if (load_mem) begin
            for (int x = 0; x < 32; x++) out_mem[x] <= 8'h00;
        end else if (out_wren) begin
            out_mem[out_address] <= out_data;
        end
    end

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] enc0;
        logic [7:0] fill;
        bit         s1_zero;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;

    wr_t        exp_q [$];
    wr_t        e;
    vec_t       rows [5];
    logic [7:0] ms [256];
    logic [7:0] ks [32];
    int         total = 0;
    int         bad = 0;
    int         nwr = 0;
    int         s_wr_cnt = 0;
    int         last_cyc = 0;
    int         cur_row = 0;
    int         exp_n = 0;
    bit         exp_fail = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference RC4 PRGA over s_init/enc_init; fills the scoreboard and keystream
    task automatic run_model(input bit stop_on_bad);
        logic [7:0] i, j, si, sj, t, o;
        i = 8'd0; j = 8'd0; exp_n = 0; exp_fail = 1'b0;
        exp_q.delete();
        for (int x = 0; x < 256; x++) ms[x] = s_init[x];
        for (int k = 0; k < MSG_LEN; k++) begin
            i = i + 8'd1; si = ms[i]; j = j + si; sj = ms[j];
            ms[i] = sj; ms[j] = si;
            t = si + sj; ks[k] = ms[t]; o = ks[k] ^ enc_init[k];
            exp_q.push_back('{addr: k[4:0], data: o});
            exp_n++;
            if (stop_on_bad && RANGE_EN &&
                !(((o >= 8'h61) && (o <= 8'h7A)) || (o == 8'h20))) begin
                exp_fail = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
        chk("rst_flags", {done_flag, fail_flag, s_wren, out_wren}, 4'b0000);
        chk("rst_s_port", {s_address, s_data_in}, 16'h0000);
        chk("rst_out_port", {rom_address, out_address, out_data}, 18'h0);
        nwr = 0; s_wr_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_flag = 1'b1;
        @(negedge clk); start_flag = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done_flag && n < 800) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done"}, done_flag, 1);
    endtask

    initial begin
        int mis, w0, s0, n;

        fork
            forever begin
                @(negedge clk);
                if (s_wren) s_wr_cnt++;
                if (out_wren) begin
                    nwr++;
                    if (nwr > 1) chk("spacing", cyc - last_cyc, 12);
                    last_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("extra_write", nwr, exp_n);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", out_address, e.addr);
                        chk("wr_data", out_data, e.data);
                        if (exp_q.size() == 0) chk("done_early", done_flag, 0);
                        if (cur_row == 0 && e.addr == 5'd1) begin
                            chk("s2_swap", s_mem[2], 8'h03);
                            chk("s3_swap", s_mem[3], 8'h02);
                        end
                    end
                end
            end
        join_none

        rows[0] = '{enc0: 8'h00, fill: 8'h00, s1_zero: 1'b0, exp0: 8'h02, exp1: 8'h05};
        rows[1] = '{enc0: 8'h63, fill: 8'h00, s1_zero: 1'b0, exp0: 8'h61, exp1: 8'h05};
        rows[2] = '{enc0: 8'h02, fill: 8'h00, s1_zero: 1'b0, exp0: 8'h00, exp1: 8'h05};
        rows[3] = '{enc0: 8'h61, fill: 8'h61, s1_zero: 1'b1, exp0: 8'h61, exp1: 8'h65};
        rows[4] = '{enc0: 8'h20, fill: 8'h20, s1_zero: 1'b0, exp0: 8'h22, exp1: 8'h25};

        for (int r = 0; r < 5; r++) begin
            cur_row = r;
            for (int x = 0; x < 256; x++) s_init[x] = x[7:0];
            if (rows[r].s1_zero) s_init[1] = 8'h00;
            for (int k = 0; k < 32; k++) enc_init[k] = (k == 0) ? rows[r].enc0 : rows[r].fill;
            run_model(1'b1);
            apply_reset();
            pulse_start();
            wait_done("row");
            chk("nwr", nwr, exp_n);
            chk("fail_flag", fail_flag, exp_fail);
            chk("q_left", exp_q.size(), 0);
            chk("out0", out_mem[0], rows[r].exp0);
            if (exp_n > 1) chk("out1", out_mem[1], rows[r].exp1);
            if (rows[r].s1_zero) chk("s1_kept", s_mem[1], 8'h00);
            mis = 0;
            for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) mis++;
            chk("s_final", mis, 0);
            w0 = nwr; s0 = s_wr_cnt;
            pulse_start();
            repeat (30) @(negedge clk);
            chk("idle_out_wr", nwr, w0);
            chk("idle_s_wr", s_wr_cnt, s0);
            chk("idle_done", done_flag, 1);
        end

        // Reset during WR_I of byte 5, then restart from k=0
        cur_row = 5;
        for (int x = 0; x < 256; x++) s_init[x] = x[7:0];
        for (int k = 0; k < 32; k++) enc_init[k] = 8'h00;
        run_model(1'b0);
        for (int k = 0; k < 32; k++) enc_init[k] = ks[k] ^ 8'h61;
        run_model(1'b1);
        apply_reset();
        pulse_start();
        n = 0;
        while (!(nwr == 5 && s_wren) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_wr_i", {nwr[7:0], 7'd0, s_wren}, {8'd5, 8'd1});
        reset = 1'b0;
        #1;
        chk("abort_wren", {s_wren, out_wren, done_flag, fail_flag}, 4'b0000);
        chk("abort_s_port", {s_address, s_data_in}, 16'h0000);
        chk("abort_out_port", {rom_address, out_address, out_data}, 18'h0);
        w0 = nwr; s0 = s_wr_cnt;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_out_wr", nwr, w0);
        chk("post_rst_s_wr", s_wr_cnt, s0);
        @(negedge clk); load_mem = 1'b1;
        @(negedge clk); load_mem = 1'b0;
        run_model(1'b1);
        nwr = 0; s_wr_cnt = 0;
        pulse_start();
        wait_done("restart");
        chk("restart_nwr", nwr, 32);
        chk("restart_out0", out_mem[0], 8'h61);
        chk("restart_fail", fail_flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
